clk_div_prog: RTL

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog.sv | 111 +++++++++++
 1 files changed

// File: rtl/clk_div_prog.sv
// Programmable multi-channel clock divider with per-channel toggle/pulse modes.
// Each channel has shadow configuration that takes effect at a safe point.
module clk_div_prog #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 29,
  parameter int unsigned DEFAULT_DIV  = 50_000_000,
  parameter bit          DEFAULT_MODE = 1'b0
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_CH-1:0]                         en,
  input  logic                                      sync_all,
  input  logic                                      cfg_wr,
  input  logic [((NUM_CH>1)?$clog2(NUM_CH):1)-1:0]  cfg_ch,
  input  logic [CNT_W-1:0]                          cfg_div,
  input  logic                                      cfg_mode,
  output logic [NUM_CH-1:0]                         clk_out,
  output logic [NUM_CH-1:0]                         tick,
  output logic [NUM_CH-1:0]                         cfg_pending
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] act_div, act_div_nxt;
    logic [CNT_W-1:0] sh_div, sh_div_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             act_mode, act_mode_nxt;
    logic             sh_mode, sh_mode_nxt;
    logic             pend, pend_nxt;
    logic             co, co_nxt;
    logic             tk, tk_nxt;
    logic             wr_hit, tc, xfer, mode_chg;

    // Out-of-range channel numbers simply match no channel.
    assign wr_hit   = cfg_wr && (cfg_ch == CH_W'(g));
    assign tc       = en[g] && (act_div != '0) && (cnt == act_div - CNT_W'(1));
    assign xfer     = pend && (tc || !en[g] || sync_all);
    assign mode_chg = xfer && (sh_mode != act_mode);

    always_comb begin
      act_div_nxt  = act_div;
      act_mode_nxt = act_mode;
      sh_div_nxt   = sh_div;
      sh_mode_nxt  = sh_mode;
      pend_nxt     = pend;
      cnt_nxt      = cnt;
      co_nxt       = co;
      tk_nxt       = 1'b0;

      if (xfer) begin
        act_div_nxt  = sh_div;
        act_mode_nxt = sh_mode;
        pend_nxt     = 1'b0;
      end
      // A write in the transfer cycle lands in the shadow and stays pending.
      if (wr_hit) begin
        sh_div_nxt  = cfg_div;
        sh_mode_nxt = cfg_mode;
        pend_nxt    = 1'b1;
      end

      if (sync_all || (act_div == '0)) begin
        cnt_nxt = '0;
        co_nxt  = 1'b0;
      end else if (en[g]) begin
        if (tc) begin
          cnt_nxt = '0;
          tk_nxt  = 1'b1;
          co_nxt  = act_mode ? 1'b1 : ~co;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (act_mode) co_nxt = 1'b0;
        end
      end

      // New mode restarts from a known phase; the TC tick itself still fires.
      if (mode_chg) begin
        cnt_nxt = '0;
        co_nxt  = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        act_div  <= CNT_W'(DEFAULT_DIV);
        act_mode <= DEFAULT_MODE;
        sh_div   <= CNT_W'(DEFAULT_DIV);
        sh_mode  <= DEFAULT_MODE;
        pend     <= 1'b0;
        cnt      <= '0;
        co       <= 1'b0;
        tk       <= 1'b0;
      end else begin
        act_div  <= act_div_nxt;
        act_mode <= act_mode_nxt;
        sh_div   <= sh_div_nxt;
        sh_mode  <= sh_mode_nxt;
        pend     <= pend_nxt;
        cnt      <= cnt_nxt;
        co       <= co_nxt;
        tk       <= tk_nxt;
      end
    end

    assign clk_out[g]     = co;
    assign tick[g]        = tk;
    assign cfg_pending[g] = pend;
  end

endmodule
